alarm_snooze_ctrl: RTL and testbench

ALARM_SNOOZE_CTRL -- requirements
Module: alarm_snooze_ctrl

---
 rtl/alarm_snooze_ctrl.sv | 119 +++++++++++
 tb/tb_alarm_snooze_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_snooze_ctrl.sv
// rtl/alarm_snooze_ctrl.sv - alarm ring/snooze/acknowledge sequencer on a 1 Hz clock
// All outputs are registers; STOP_al requests the upstream time-keeper to drop Alarm.
module alarm_snooze_ctrl #(
  parameter int SNOOZE_SEC   = 300,
  parameter int RING_TIMEOUT = 60,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       reset,
  input  logic       clk_1s,
  input  logic       Alarm,
  input  logic       SNOOZE_btn,
  input  logic       STOP_btn,
  output logic       STOP_al,
  output logic       Buzzer,
  output logic [1:0] state,
  output logic [1:0] snooze_cnt,
  output logic [8:0] remain,
  output logic       Missed
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    ACK     = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  localparam logic [1:0] MAX_CNT    = 2'(MAX_SNOOZE);
  localparam logic [8:0] SNOOZE_LEN = 9'(SNOOZE_SEC);
  localparam logic [6:0] RING_LAST  = 7'(RING_TIMEOUT - 1);

  state_t     r_state;
  logic       r_stop_al;
  logic       r_buzzer;
  logic [1:0] r_snooze_cnt;
  logic [8:0] r_remain;
  logic       r_missed;
  logic [6:0] r_ring_timer;

  logic w_can_snooze;
  logic w_ring_done;

  assign w_can_snooze = (r_snooze_cnt < MAX_CNT);
  assign w_ring_done  = (r_ring_timer == RING_LAST);

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_stop_al    <= 1'b0;
      r_buzzer     <= 1'b0;
      r_snooze_cnt <= 2'd0;
      r_remain     <= 9'd0;
      r_missed     <= 1'b0;
      r_ring_timer <= 7'd0;
    end else begin
      // STOP_al holds only while Alarm is still asserted; a new request below overrides.
      r_stop_al <= r_stop_al & Alarm;
      r_buzzer  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Alarm) begin
            r_state      <= RINGING;
            r_ring_timer <= 7'd0;
            r_snooze_cnt <= 2'd0;
            r_missed     <= 1'b0;
            r_buzzer     <= 1'b1;
          end
        end
        RINGING: begin
          if (STOP_btn) begin
            r_state   <= ACK;
            r_stop_al <= 1'b1;
          end else if ((SNOOZE_btn || w_ring_done) && w_can_snooze) begin
            r_state      <= SNOOZE;
            r_snooze_cnt <= r_snooze_cnt + 2'd1;
            r_remain     <= SNOOZE_LEN;
            r_stop_al    <= 1'b1;
          end else if (w_ring_done) begin
            r_state   <= ACK;
            r_stop_al <= 1'b1;
            r_missed  <= 1'b1;
          end else begin
            // An exhausted snooze press counts as no button, so the timeout still applies.
            r_ring_timer <= r_ring_timer + 7'd1;
            r_buzzer     <= ~r_buzzer;
          end
        end
        SNOOZE: begin
          if (STOP_btn) begin
            r_state      <= IDLE;
            r_remain     <= 9'd0;
            r_snooze_cnt <= 2'd0;
          end else if (r_remain <= 9'd1) begin
            r_state      <= RINGING;
            r_ring_timer <= 7'd0;
            r_remain     <= 9'd0;
            r_buzzer     <= 1'b1;
          end else begin
            r_remain <= r_remain - 9'd1;
          end
        end
        ACK: begin
          if (!Alarm) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign STOP_al    = r_stop_al;
  assign Buzzer     = r_buzzer;
  assign state      = r_state;
  assign snooze_cnt = r_snooze_cnt;
  assign remain     = r_remain;
  assign Missed     = r_missed;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// tb/tb_alarm_snooze_ctrl.sv - vector table, corner sequences and random run vs a timestamp model
// The model tracks ring/snooze start times and derives timer, remain and Buzzer arithmetically.
module tb_alarm_snooze_ctrl;

  localparam int SS = 5;
  localparam int RT = 4;
  localparam int MS = 2;

  logic       clk_1s = 1'b0;
  logic       reset = 1'b0;
  logic       Alarm = 1'b0;
  logic       SNOOZE_btn = 1'b0;
  logic       STOP_btn = 1'b0;
  logic       STOP_al;
  logic       Buzzer;
  logic [1:0] state;
  logic [1:0] snooze_cnt;
  logic [8:0] remain;
  logic       Missed;

  int n_pass = 0;
  int n_total = 0;

  alarm_snooze_ctrl #(.SNOOZE_SEC(SS), .RING_TIMEOUT(RT), .MAX_SNOOZE(MS)) dut (
    .reset(reset), .clk_1s(clk_1s), .Alarm(Alarm), .SNOOZE_btn(SNOOZE_btn),
    .STOP_btn(STOP_btn), .STOP_al(STOP_al), .Buzzer(Buzzer), .state(state),
    .snooze_cnt(snooze_cnt), .remain(remain), .Missed(Missed)
  );

  always #5 clk_1s = ~clk_1s;

  typedef struct {
    logic a, sn, st;
    logic [1:0] s;
    logic b, sa;
    logic [1:0] c;
    logic [8:0] r;
    logic m;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] pk(input int s, input int b, input int sa, input int c,
                                     input int r, input int m);
    return {2'(s), 1'(b), 1'(sa), 2'(c), 9'(r), 1'(m)};
  endfunction

  function void addv(input int a, input int sn, input int st, input int s, input int b,
                     input int sa, input int c, input int r, input int m);
    vec_t v;
    v.a = 1'(a); v.sn = 1'(sn); v.st = 1'(st);
    v.s = 2'(s); v.b = 1'(b); v.sa = 1'(sa); v.c = 2'(c); v.r = 9'(r); v.m = 1'(m);
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] got;
    got = {state, Buzzer, STOP_al, snooze_cnt, remain, Missed};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got state=%0d buz=%b stop_al=%b cnt=%0d remain=%0d missed=%b, expected state=%0d buz=%b stop_al=%b cnt=%0d remain=%0d missed=%b",
                  name, got[15:14], got[13], got[12], got[11:10], got[9:1], got[0],
                  exp[15:14], exp[13], exp[12], exp[11:10], exp[9:1], exp[0]);
  endtask

  // Reference model: times are counted in edges since the last reset.
  int m_phase, m_now, m_ring_start, m_snz_start, m_used;
  bit m_missed, m_stop;

  function void m_reset();
    m_phase = 0; m_now = 0; m_ring_start = 0; m_snz_start = 0; m_used = 0;
    m_missed = 0; m_stop = 0;
  endfunction

  function void m_edge(input bit a, input bit sn, input bit st);
    bit ns;
    int age, rem;
    ns  = m_stop && a;
    age = m_now - m_ring_start;
    rem = SS - (m_now - m_snz_start);
    case (m_phase)
      0: if (a) begin m_phase = 1; m_ring_start = m_now + 1; m_used = 0; m_missed = 0; end
      1: begin
        if (st) begin m_phase = 2; ns = 1; end
        else if (m_used < MS && (sn || age == RT - 1)) begin
          m_phase = 3; m_used++; m_snz_start = m_now + 1; ns = 1;
        end else if (age == RT - 1) begin m_phase = 2; m_missed = 1; ns = 1; end
      end
      2: if (!a) m_phase = 0;
      default: begin
        if (st) begin m_phase = 0; m_used = 0; end
        else if (rem == 1) begin m_phase = 1; m_ring_start = m_now + 1; end
      end
    endcase
    m_stop = ns;
    m_now++;
  endfunction

  function automatic logic [15:0] m_out();
    int b, r;
    b = (m_phase == 1 && ((m_now - m_ring_start) % 2 == 0)) ? 1 : 0;
    r = (m_phase == 3) ? SS - (m_now - m_snz_start) : 0;
    return pk(m_phase, b, int'(m_stop), m_used, r, int'(m_missed));
  endfunction

  task automatic step(input logic a, input logic sn, input logic st);
    Alarm = a; SNOOZE_btn = sn; STOP_btn = st;
    @(posedge clk_1s);
    #1;
  endtask

  task automatic steps(input int n, input logic a, input logic sn, input logic st);
    for (int i = 0; i < n; i++) step(a, sn, st);
  endtask

  task automatic do_reset();
    Alarm = 0; SNOOZE_btn = 0; STOP_btn = 0;
    reset = 1; #2; reset = 0;
    m_reset();
  endtask

  initial begin
    #1 reset = 1;
    #2 check("reset_state", pk(0, 0, 0, 0, 0, 0));
    @(posedge clk_1s); #1;
    reset = 0;
    m_reset();

    // stop at ring cycle 2; both buttons; snooze and return; snooze exhaustion
    addv(1,0,0, 1,1,0,0,0,0); addv(1,0,0, 1,0,0,0,0,0); addv(1,0,1, 2,0,1,0,0,0);
    addv(1,0,0, 2,0,1,0,0,0); addv(0,0,0, 0,0,0,0,0,0); addv(0,0,0, 0,0,0,0,0,0);
    addv(1,0,0, 1,1,0,0,0,0); addv(1,1,1, 2,0,1,0,0,0); addv(0,0,0, 0,0,0,0,0,0);
    addv(1,0,0, 1,1,0,0,0,0); addv(1,1,0, 3,0,1,1,5,0); addv(1,0,0, 3,0,1,1,4,0);
    addv(1,0,0, 3,0,1,1,3,0); addv(0,0,0, 3,0,0,1,2,0); addv(0,0,0, 3,0,0,1,1,0);
    addv(0,0,0, 1,1,0,1,0,0); addv(0,0,0, 1,0,0,1,0,0); addv(1,0,1, 2,0,1,1,0,0);
    addv(0,0,0, 0,0,0,1,0,0);
    addv(1,0,0, 1,1,0,0,0,0); addv(1,1,0, 3,0,1,1,5,0); addv(1,0,0, 3,0,1,1,4,0);
    addv(1,0,0, 3,0,1,1,3,0); addv(1,0,0, 3,0,1,1,2,0); addv(1,0,0, 3,0,1,1,1,0);
    addv(1,0,0, 1,1,1,1,0,0); addv(1,1,0, 3,0,1,2,5,0); addv(1,0,0, 3,0,1,2,4,0);
    addv(1,0,0, 3,0,1,2,3,0); addv(1,0,0, 3,0,1,2,2,0); addv(1,0,0, 3,0,1,2,1,0);
    addv(1,0,0, 1,1,1,2,0,0); addv(1,1,0, 1,0,1,2,0,0); addv(1,1,0, 1,1,1,2,0,0);
    addv(1,0,1, 2,0,1,2,0,0); addv(0,0,0, 0,0,0,2,0,0);
    foreach (tbl[i]) begin
      step(tbl[i].a, tbl[i].sn, tbl[i].st);
      check($sformatf("tbl%0d", i),
            {tbl[i].s, tbl[i].b, tbl[i].sa, tbl[i].c, tbl[i].r, tbl[i].m});
    end

    // unattended alarm: two auto-snoozes, then missed
    do_reset();
    steps(4, 1, 0, 0); check("auto_ring4", pk(1, 0, 0, 0, 0, 0));
    step(1, 0, 0);     check("auto_snz1", pk(3, 0, 1, 1, 5, 0));
    steps(5, 1, 0, 0); check("auto_ring2", pk(1, 1, 1, 1, 0, 0));
    steps(4, 1, 0, 0); check("auto_snz2", pk(3, 0, 1, 2, 5, 0));
    steps(5, 1, 0, 0); check("auto_ring3", pk(1, 1, 1, 2, 0, 0));
    steps(4, 1, 0, 0); check("auto_missed", pk(2, 0, 1, 2, 0, 1));
    step(0, 0, 0);     check("missed_held", pk(0, 0, 0, 2, 0, 1));
    step(1, 0, 0);     check("missed_clear", pk(1, 1, 0, 0, 0, 0));

    // asynchronous reset mid-snooze, then immediate response after release
    do_reset();
    step(1, 0, 0); step(1, 1, 0); steps(2, 1, 0, 0);
    check("snz_rem3", pk(3, 0, 1, 1, 3, 0));
    reset = 1; #2;
    check("async_reset", pk(0, 0, 0, 0, 0, 0));
    #1 reset = 0;
    step(1, 0, 0); check("first_edge_after_reset", pk(1, 1, 0, 0, 0, 0));

    // stop during snooze
    do_reset();
    step(1, 0, 0); step(1, 1, 0); steps(3, 1, 0, 0);
    check("snz_rem2", pk(3, 0, 1, 1, 2, 0));
    step(1, 0, 1); check("snz_stop", pk(0, 0, 1, 0, 0, 0));

    // randomized run against the model
    do_reset();
    begin
      logic a;
      a = 0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(99) < 2) begin
          reset = 1; #1;
          m_reset();
          check($sformatf("rand_reset%0d", i), m_out());
          #1 reset = 0;
        end else begin
          if ($urandom_range(99) < 20) a = ~a;
          step(a, 1'($urandom_range(99) < 20), 1'($urandom_range(99) < 10));
          m_edge(Alarm, SNOOZE_btn, STOP_btn);
          check($sformatf("rand%0d", i), m_out());
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
